// File: rtl/flash_cache_bridge_if.sv
// flash_cache_bridge_if
//  CPU-side native-bus bundle between the PicoRV32 memory decoder and the
//  flash cache bridge.
//  Signals:
//   select  request strobe (mem_valid & address decode)
//   wstrb   0000 read, 1111 word program, 0001 row erase
//   addr    word address
//   data_i  write data
//   ready   one-cycle completion pulse
//   data_o  read data, held until the next completion
//   bus_err pulses with ready on timeout or illegal wstrb
//  Modports: master = CPU/decoder side, slave = bridge side.
interface flash_cache_bridge_if #(
  parameter int ADDR_W = 15
);
  logic              select;
  logic [3:0]        wstrb;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       data_i;
  logic              ready;
  logic [31:0]       data_o;
  logic              bus_err;

  modport master (
    output select, wstrb, addr, data_i,
    input  ready, data_o, bus_err
  );

  modport slave (
    input  select, wstrb, addr, data_i,
    output ready, data_o, bus_err
  );
endinterface

// File: rtl/flash_cache_bridge.sv
// flash_cache_bridge
//  PicoRV32 native-bus slave in front of the Gowin user-flash controller.
//  Adds a direct-mapped, one-word-per-line read cache, a row/column address
//  split, a controller timeout with error reporting, and hit/miss counters.
//  Ports:
//   clk, reset         system clock, asynchronous active-high reset
//   bus (slave)        CPU request/response bundle (see flash_cache_bridge_if)
//   hit_cnt, miss_cnt  saturating cache hit / flash-read counters
//   fc_start           one-cycle start pulse to the controller
//   fc_done            controller completion pulse
//   fc_wr_en           registered program request
//   fc_erase_en        registered erase request
//   fc_xaddr, fc_yaddr registered row / column address
//   fc_wdata           registered write data
//   fc_rdata           controller read data, sampled while fc_done=1
module flash_cache_bridge #(
  parameter int COL_W    = 6,
  parameter int ROW_W    = 9,
  parameter int LINES    = 16,
  parameter bit CACHE_EN = 1'b1,
  parameter int TIMEOUT  = 1023
) (
  input  logic                 clk,
  input  logic                 reset,
  flash_cache_bridge_if.slave  bus,
  output logic [31:0]          hit_cnt,
  output logic [31:0]          miss_cnt,
  output logic                 fc_start,
  input  logic                 fc_done,
  output logic                 fc_wr_en,
  output logic                 fc_erase_en,
  output logic [ROW_W-1:0]     fc_xaddr,
  output logic [COL_W-1:0]     fc_yaddr,
  output logic [31:0]          fc_wdata,
  input  logic [31:0]          fc_rdata
);

  localparam int ADDR_W = ROW_W + COL_W;
  localparam int IDX_W  = $clog2(LINES);
  localparam int TAG_W  = ADDR_W - IDX_W;
  localparam int CNT_W  = $clog2(TIMEOUT + 1);

  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  localparam logic [1:0] OP_READ  = 2'd0;
  localparam logic [1:0] OP_PROG  = 2'd1;
  localparam logic [1:0] OP_ERASE = 2'd2;

  logic [1:0]        state;
  logic [1:0]        op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [CNT_W-1:0]  to_cnt;
  logic [LINES-1:0]  valid;

  logic [TAG_W-1:0]  tag_mem  [LINES];
  logic [31:0]       data_mem [LINES];

  logic [IDX_W-1:0]  req_idx;
  logic [TAG_W-1:0]  req_tag;
  logic [IDX_W-1:0]  acc_idx;
  logic [TAG_W-1:0]  acc_tag;
  logic              is_read, is_prog, is_erase, is_illegal;
  logic              req_hit;
  logic              fill_en;

  assign req_idx = bus.addr[IDX_W-1:0];
  assign req_tag = bus.addr[ADDR_W-1:IDX_W];
  assign acc_idx = addr_q[IDX_W-1:0];
  assign acc_tag = addr_q[ADDR_W-1:IDX_W];

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    is_read    = 1'b0;
    is_prog    = 1'b0;
    is_erase   = 1'b0;
    is_illegal = 1'b0;
    case (bus.wstrb)
      4'b0000: is_read    = 1'b1;
      4'b1111: is_prog    = 1'b1;
      4'b0001: is_erase   = 1'b1;
      default: is_illegal = 1'b1;
    endcase
  end

  assign req_hit = CACHE_EN && valid[req_idx] && (tag_mem[req_idx] == req_tag);

  // A line is refilled only by a read that the controller actually answered.
  assign fill_en = CACHE_EN && (state == S_ACCESS) && fc_done && (op_q == OP_READ);

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // NOTE: tag/data storage has no reset; the valid bits alone say whether a
  // line holds anything, which keeps the arrays mappable to plain RAM.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      tag_mem[acc_idx]  <= acc_tag;
      data_mem[acc_idx] <= fc_rdata;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register sees pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      op_q        <= OP_READ;
      addr_q      <= '0;
      to_cnt      <= '0;
      valid       <= '0;
      hit_cnt     <= '0;
      miss_cnt    <= '0;
      fc_start    <= 1'b0;
      fc_wr_en    <= 1'b0;
      fc_erase_en <= 1'b0;
      fc_xaddr    <= '0;
      fc_yaddr    <= '0;
      fc_wdata    <= '0;
      bus.ready   <= 1'b0;
      bus.bus_err <= 1'b0;
      bus.data_o  <= '0;
    end else begin
      // Pulses: high for the single cycle after the edge that sets them.
      fc_start    <= 1'b0;
      bus.ready   <= 1'b0;
      bus.bus_err <= 1'b0;

      case (state)
        S_IDLE: begin
          if (bus.select) begin
            if (is_illegal) begin
              bus.bus_err <= 1'b1;
              bus.ready   <= 1'b1;
              state       <= S_DONE;
            end else if (is_read && req_hit) begin
              bus.data_o <= data_mem[req_idx];
              hit_cnt    <= sat_inc(hit_cnt);
              bus.ready  <= 1'b1;
              state      <= S_DONE;
            end else begin
              fc_xaddr    <= bus.addr[ADDR_W-1:COL_W];
              fc_yaddr    <= bus.addr[COL_W-1:0];
              fc_wdata    <= bus.data_i;
              fc_wr_en    <= is_prog;
              fc_erase_en <= is_erase;
              fc_start    <= 1'b1;
              addr_q      <= bus.addr;
              op_q        <= is_prog ? OP_PROG : (is_erase ? OP_ERASE : OP_READ);
              to_cnt      <= '0;
              if (is_read) miss_cnt <= sat_inc(miss_cnt);
              state       <= S_ACCESS;
            end
          end
        end

        S_ACCESS: begin
          to_cnt <= to_cnt + CNT_W'(1);
          // fc_done is tested first so a completion in the timeout cycle wins.
          if (fc_done) begin
            case (op_q)
              OP_READ: begin
                bus.data_o <= fc_rdata;
                if (CACHE_EN) valid[acc_idx] <= 1'b1;
              end
              OP_PROG:  valid[acc_idx] <= 1'b0;
              OP_ERASE: valid <= '0;
              default:  ;
            endcase
            bus.ready <= 1'b1;
            state     <= S_DONE;
          end else if (to_cnt == TO_LAST) begin
            bus.data_o  <= 32'hFFFF_FFFF;
            bus.bus_err <= 1'b1;
            bus.ready   <= 1'b1;
            state       <= S_DONE;
          end
        end

        // One dead cycle so a select still high from this request cannot
        // start a second one.
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_flash_cache_bridge.sv
// tb_flash_cache_bridge
//  Directed bench for flash_cache_bridge with a small flash-controller
//  responder (programmable latency/data, can be told to never answer).
module tb_flash_cache_bridge;
  localparam int COL_W   = 6;
  localparam int ROW_W   = 9;
  localparam int ADDR_W  = ROW_W + COL_W;
  localparam int TIMEOUT = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  flash_cache_bridge_if #(.ADDR_W(ADDR_W)) bus ();

  logic [31:0]      hit_cnt, miss_cnt;
  logic             fc_start, fc_done, fc_wr_en, fc_erase_en;
  logic [ROW_W-1:0] fc_xaddr;
  logic [COL_W-1:0] fc_yaddr;
  logic [31:0]      fc_wdata, fc_rdata;

  flash_cache_bridge #(
    .COL_W(COL_W), .ROW_W(ROW_W), .LINES(16), .CACHE_EN(1'b1), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt),
    .fc_start(fc_start), .fc_done(fc_done), .fc_wr_en(fc_wr_en),
    .fc_erase_en(fc_erase_en), .fc_xaddr(fc_xaddr), .fc_yaddr(fc_yaddr),
    .fc_wdata(fc_wdata), .fc_rdata(fc_rdata)
  );

  int checks = 0;
  int errors = 0;
  int start_cnt = 0;

  bit          ctrl_respond = 1'b1;
  int          ctrl_lat     = 5;
  logic [31:0] ctrl_data    = 32'h0;

  always @(negedge clk) if (fc_start === 1'b1) start_cnt++;

  // Controller model: fc_done follows the start pulse by ctrl_lat cycles.
  initial begin
    fc_done  = 1'b0;
    fc_rdata = 32'h0;
    forever begin
      @(negedge clk);
      if (fc_start === 1'b1 && ctrl_respond) begin
        repeat (ctrl_lat - 1) @(negedge clk);
        fc_done  = 1'b1;
        fc_rdata = ctrl_data;
        @(negedge clk);
        fc_done  = 1'b0;
        fc_rdata = 32'h0;
      end
    end
  end

  task automatic do_req(input logic [3:0] ws, input logic [ADDR_W-1:0] a,
                        input logic [31:0] d, output logic [31:0] rd,
                        output logic err, output int cyc);
    repeat (2) @(negedge clk);
    bus.select = 1'b1;
    bus.wstrb  = ws;
    bus.addr   = a;
    bus.data_i = d;
    @(negedge clk);
    bus.select = 1'b0;
    cyc = 1;
    while (bus.ready !== 1'b1 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (bus.ready !== 1'b1) begin
      errors++;
      $display("FAIL req_ready: ready=%b after %0d cycles, required 1", bus.ready, cyc);
    end
    rd  = bus.data_o;
    err = bus.bus_err;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.ready, bus.bus_err, bus.data_o, hit_cnt, miss_cnt} !== '0) begin
      errors++;
      $display("FAIL reset_bus: ready=%b err=%b data=%h hit=%0d miss=%0d, required all 0",
               bus.ready, bus.bus_err, bus.data_o, hit_cnt, miss_cnt);
    end
    checks++;
    if ({fc_start, fc_wr_en, fc_erase_en, fc_xaddr, fc_yaddr, fc_wdata} !== '0) begin
      errors++;
      $display("FAIL reset_fc: start=%b wr=%b er=%b x=%h y=%h wd=%h, required all 0",
               fc_start, fc_wr_en, fc_erase_en, fc_xaddr, fc_yaddr, fc_wdata);
    end
    reset = 1'b0;
  endtask

  task automatic test_cold_read();
    logic [31:0] rd; logic err; int cyc; int s0;
    ctrl_data = 32'hDEAD_BEEF; ctrl_lat = 5; s0 = start_cnt;
    do_req(4'b0000, 15'h0041, 32'h0, rd, err, cyc);
    checks++;
    if (rd !== 32'hDEAD_BEEF || err !== 1'b0) begin
      errors++; $display("FAIL cold_data: data=%h err=%b, required deadbeef/0", rd, err);
    end
    checks++;
    if (fc_xaddr !== 9'd1 || fc_yaddr !== 6'd1) begin
      errors++; $display("FAIL cold_addr: x=%h y=%h, required 1/1", fc_xaddr, fc_yaddr);
    end
    checks++;
    if (start_cnt - s0 != 1) begin
      errors++; $display("FAIL cold_start: %0d start pulses, required 1", start_cnt - s0);
    end
    checks++;
    if (miss_cnt !== 32'd1 || fc_wr_en !== 1'b0 || fc_erase_en !== 1'b0) begin
      errors++; $display("FAIL cold_miss: miss=%0d wr=%b er=%b, required 1/0/0",
                         miss_cnt, fc_wr_en, fc_erase_en);
    end
    checks++;
    if (cyc != 6) begin
      errors++; $display("FAIL cold_latency: %0d cycles, required 6", cyc);
    end
  endtask

  task automatic test_hit();
    logic [31:0] rd; logic err; int cyc; int s0;
    ctrl_data = 32'h0; s0 = start_cnt;
    do_req(4'b0000, 15'h0041, 32'h0, rd, err, cyc);
    checks++;
    if (cyc != 1 || rd !== 32'hDEAD_BEEF || start_cnt != s0) begin
      errors++; $display("FAIL hit: cycles=%0d data=%h starts=%0d, required 1/deadbeef/0",
                         cyc, rd, start_cnt - s0);
    end
    checks++;
    if (hit_cnt !== 32'd1 || miss_cnt !== 32'd1) begin
      errors++; $display("FAIL hit_cnt: hit=%0d miss=%0d, required 1/1", hit_cnt, miss_cnt);
    end
    @(negedge clk);
    checks++;
    if (bus.ready !== 1'b0) begin
      errors++; $display("FAIL ready_pulse: ready=%b one cycle later, required 0", bus.ready);
    end
  endtask

  task automatic test_program();
    logic [31:0] rd; logic err; int cyc; int s0;
    ctrl_data = 32'hCAFE_0051; s0 = start_cnt;
    do_req(4'b0000, 15'h0051, 32'h0, rd, err, cyc);
    do_req(4'b0000, 15'h0051, 32'h0, rd, err, cyc);
    checks++;
    if (rd !== 32'hCAFE_0051 || start_cnt - s0 != 1 || miss_cnt !== 32'd2 || hit_cnt !== 32'd2) begin
      errors++; $display("FAIL conflict_refill: data=%h starts=%0d miss=%0d hit=%0d, required cafe0051/1/2/2",
                         rd, start_cnt - s0, miss_cnt, hit_cnt);
    end
    s0 = start_cnt;
    do_req(4'b1111, 15'h0051, 32'h1234_5678, rd, err, cyc);
    checks++;
    if (fc_wr_en !== 1'b1 || fc_erase_en !== 1'b0 || fc_wdata !== 32'h1234_5678 ||
        fc_xaddr !== 9'd1 || fc_yaddr !== 6'h11 || err !== 1'b0 || start_cnt - s0 != 1) begin
      errors++; $display("FAIL program: wr=%b er=%b wd=%h x=%h y=%h err=%b starts=%0d, required 1/0/12345678/1/11/0/1",
                         fc_wr_en, fc_erase_en, fc_wdata, fc_xaddr, fc_yaddr, err, start_cnt - s0);
    end
    ctrl_data = 32'h1234_5678; s0 = start_cnt;
    do_req(4'b0000, 15'h0051, 32'h0, rd, err, cyc);
    checks++;
    if (start_cnt - s0 != 1 || miss_cnt !== 32'd3 || rd !== 32'h1234_5678) begin
      errors++; $display("FAIL program_invalidate: starts=%0d miss=%0d data=%h, required 1/3/12345678",
                         start_cnt - s0, miss_cnt, rd);
    end
  endtask

  task automatic test_erase();
    logic [31:0] rd; logic err; int cyc; int s0; int bad;
    for (int i = 2; i < 6; i++) begin
      ctrl_data = 32'hA000_0000 | i;
      do_req(4'b0000, ADDR_W'(i), 32'h0, rd, err, cyc);
    end
    bad = 0; s0 = start_cnt; ctrl_data = 32'h0;
    for (int i = 2; i < 6; i++) begin
      do_req(4'b0000, ADDR_W'(i), 32'h0, rd, err, cyc);
      if (rd !== (32'hA000_0000 | i) || cyc != 1) bad++;
    end
    checks++;
    if (bad != 0 || start_cnt != s0 || hit_cnt !== 32'd6 || miss_cnt !== 32'd7) begin
      errors++; $display("FAIL fill_hits: bad=%0d starts=%0d hit=%0d miss=%0d, required 0/0/6/7",
                         bad, start_cnt - s0, hit_cnt, miss_cnt);
    end
    s0 = start_cnt;
    do_req(4'b0001, 15'h0003, 32'h0, rd, err, cyc);
    checks++;
    if (fc_erase_en !== 1'b1 || fc_wr_en !== 1'b0 || err !== 1'b0 || start_cnt - s0 != 1) begin
      errors++; $display("FAIL erase: er=%b wr=%b err=%b starts=%0d, required 1/0/0/1",
                         fc_erase_en, fc_wr_en, err, start_cnt - s0);
    end
    s0 = start_cnt; ctrl_data = 32'h0BAD_F00D;
    for (int i = 2; i < 6; i++) do_req(4'b0000, ADDR_W'(i), 32'h0, rd, err, cyc);
    checks++;
    if (start_cnt - s0 != 4 || miss_cnt !== 32'd11 || rd !== 32'h0BAD_F00D) begin
      errors++; $display("FAIL erase_invalidate: starts=%0d miss=%0d data=%h, required 4/11/0badf00d",
                         start_cnt - s0, miss_cnt, rd);
    end
  endtask

  task automatic test_timeout();
    logic [31:0] rd; logic err; int cyc; int s0;
    ctrl_respond = 1'b0;
    do_req(4'b0000, 15'h0100, 32'h0, rd, err, cyc);
    checks++;
    if (err !== 1'b1 || rd !== 32'hFFFF_FFFF || cyc != TIMEOUT + 1) begin
      errors++; $display("FAIL timeout: err=%b data=%h cycles=%0d, required 1/ffffffff/%0d",
                         err, rd, cyc, TIMEOUT + 1);
    end
    ctrl_respond = 1'b1; ctrl_data = 32'h55AA_55AA; s0 = start_cnt;
    do_req(4'b0000, 15'h0100, 32'h0, rd, err, cyc);
    checks++;
    if (err !== 1'b0 || rd !== 32'h55AA_55AA || start_cnt - s0 != 1 || miss_cnt !== 32'd13) begin
      errors++; $display("FAIL after_timeout: err=%b data=%h starts=%0d miss=%0d, required 0/55aa55aa/1/13",
                         err, rd, start_cnt - s0, miss_cnt);
    end
    ctrl_lat = TIMEOUT; ctrl_data = 32'h7777_0200;
    do_req(4'b0000, 15'h0200, 32'h0, rd, err, cyc);
    checks++;
    if (err !== 1'b0 || rd !== 32'h7777_0200 || cyc != TIMEOUT + 1) begin
      errors++; $display("FAIL done_wins: err=%b data=%h cycles=%0d, required 0/77770200/%0d",
                         err, rd, cyc, TIMEOUT + 1);
    end
    ctrl_lat = TIMEOUT + 1; ctrl_data = 32'h7777_0300;
    do_req(4'b0000, 15'h0300, 32'h0, rd, err, cyc);
    checks++;
    if (err !== 1'b1 || rd !== 32'hFFFF_FFFF || miss_cnt !== 32'd15) begin
      errors++; $display("FAIL late_done: err=%b data=%h miss=%0d, required 1/ffffffff/15",
                         err, rd, miss_cnt);
    end
    ctrl_lat = 5;
  endtask

  task automatic test_illegal();
    logic [31:0] rd; logic err; int cyc; int s0;
    s0 = start_cnt;
    do_req(4'b0011, 15'h0041, 32'h0, rd, err, cyc);
    checks++;
    if (cyc != 1 || err !== 1'b1 || start_cnt != s0 || miss_cnt !== 32'd15 || hit_cnt !== 32'd6) begin
      errors++; $display("FAIL illegal: cycles=%0d err=%b starts=%0d miss=%0d hit=%0d, required 1/1/0/15/6",
                         cyc, err, start_cnt - s0, miss_cnt, hit_cnt);
    end
    @(negedge clk);
    checks++;
    if (bus.bus_err !== 1'b0 || bus.ready !== 1'b0) begin
      errors++; $display("FAIL err_pulse: err=%b ready=%b one cycle later, required 0/0", bus.bus_err, bus.ready);
    end
  endtask

  task automatic test_reset_mid_access();
    logic [31:0] rd; logic err; int cyc; int s0;
    ctrl_data = 32'h0000_0707;
    do_req(4'b0000, 15'h0007, 32'h0, rd, err, cyc);
    do_req(4'b0000, 15'h0007, 32'h0, rd, err, cyc);
    checks++;
    if (cyc != 1 || hit_cnt !== 32'd7 || miss_cnt !== 32'd16) begin
      errors++; $display("FAIL pre_reset_hit: cycles=%0d hit=%0d miss=%0d, required 1/7/16", cyc, hit_cnt, miss_cnt);
    end
    ctrl_respond = 1'b0;
    @(negedge clk);
    bus.select = 1'b1; bus.wstrb = 4'b0000; bus.addr = 15'h0123;
    @(negedge clk);
    bus.select = 1'b0;
    #2 reset = 1'b1;
    #1;
    checks++;
    if (fc_start !== 1'b0 || bus.ready !== 1'b0 || hit_cnt !== 32'd0 || miss_cnt !== 32'd0) begin
      errors++; $display("FAIL reset_async: start=%b ready=%b hit=%0d miss=%0d, required 0/0/0/0",
                         fc_start, bus.ready, hit_cnt, miss_cnt);
    end
    @(negedge clk);
    reset = 1'b0;
    ctrl_respond = 1'b1; ctrl_data = 32'h0000_7070; s0 = start_cnt;
    do_req(4'b0000, 15'h0007, 32'h0, rd, err, cyc);
    checks++;
    if (start_cnt - s0 != 1 || miss_cnt !== 32'd1 || rd !== 32'h0000_7070 || err !== 1'b0) begin
      errors++; $display("FAIL reset_invalidate: starts=%0d miss=%0d data=%h err=%b, required 1/1/00007070/0",
                         start_cnt - s0, miss_cnt, rd, err);
    end
  endtask

  initial begin
    reset      = 1'b1;
    bus.select = 1'b0;
    bus.wstrb  = 4'b0000;
    bus.addr   = '0;
    bus.data_i = 32'h0;
    test_reset();
    test_cold_read();
    test_hit();
    test_program();
    test_erase();
    test_timeout();
    test_illegal();
    test_reset_mid_access();
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at 200000 time units, required completion");
    $fatal(1);
  end
endmodule
